// File: rtl/io_periph_v1_pkg.sv
// io_periph_v1_pkg: bus select codes, digit register layout and 7-segment table
package io_periph_v1_pkg;

    localparam logic [4:0] SEL_NONE     = 5'd0;
    localparam logic [4:0] SEL_SEG0     = 5'd1;
    localparam logic [4:0] SEL_SEG1     = 5'd2;
    localparam logic [4:0] SEL_BTN      = 5'd3;
    localparam logic [4:0] SEL_BTN_EDGE = 5'd4;

    localparam int SEG_EN_BIT    = 4;
    localparam int SEG_DIGIT_MSB = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       en;
        logic [3:0] digit;
    } seg_reg_t;

    // active-low {g..a} patterns for hex digits 0-F
    localparam logic [6:0] HEX7SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_decode(input seg_reg_t r);
        return r.en ? HEX7SEG[r.digit] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/io_periph_v1_if.sv
// io_periph_v1_if: memory-controller side select/strobe/data bus
interface io_periph_v1_if;
    logic [4:0]  sel_mux_data_in;
    logic [4:0]  sel_mux_data_out;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output sel_mux_data_in, sel_mux_data_out, wr_en, rd_en, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  sel_mux_data_in, sel_mux_data_out, wr_en, rd_en, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/io_periph_v1_btn_debounce.sv
// io_periph_v1_btn_debounce: per-bit synchroniser, stability counter and rise detect
module io_periph_v1_btn_debounce #(
    parameter int NUM_BTN         = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] raw,
    output logic [NUM_BTN-1:0] stable,
    output logic [NUM_BTN-1:0] rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [NUM_BTN-1:0] sync1_q, sync2_q, stable_q, stable_d;
    logic [CW-1:0]      cnt_q [NUM_BTN];
    logic [CW-1:0]      cnt_d [NUM_BTN];

    // a bit is accepted once it has differed from stable for DEBOUNCE_CYCLES cycles
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
                          ? sync2_q[i] : stable_q[i];
            cnt_d[i]    = (sync2_q[i] != stable_q[i] && cnt_q[i] != CW'(DEBOUNCE_CYCLES - 1))
                          ? cnt_q[i] + 1'b1 : '0;
        end
    end

    assign stable = stable_q;
    assign rise   = stable_d & ~stable_q;

    // synchroniser, debounce counters and accepted levels
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/io_periph_v1.sv
// io_periph_v1: memory-mapped digit registers, display scan and debounced buttons
module io_periph_v1
    import io_periph_v1_pkg::*;
#(
    parameter int NUM_BTN         = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 1024
) (
    input  logic               clk,
    input  logic               rst,
    io_periph_v1_if.slave      bus,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [6:0]         seg_cathode,
    output logic [1:0]         seg_anode
);
    localparam int SW = $clog2(SCAN_DIV);

    seg_reg_t           seg0_q, seg0_d, seg1_q, seg1_d;
    logic [NUM_BTN-1:0] btn_stable, btn_rise, edge_q, edge_d;
    logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
    logic               scan_digit_q, scan_digit_d, scan_wrap;
    logic [31:0]        rd_data_q, rd_mux;
    logic               rd_valid_q;
    logic [6:0]         seg_cathode_q;
    logic [1:0]         seg_anode_q;
    logic               unused_wr_data;

    assign unused_wr_data = ^bus.wr_data[31:5];

    io_periph_v1_btn_debounce #(
        .NUM_BTN        (NUM_BTN),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_in),
        .stable(btn_stable),
        .rise  (btn_rise)
    );

    // register writes, clear-on-read edge capture (set wins), read mux and scan timer
    always_comb begin
        seg0_d       = (bus.wr_en && bus.sel_mux_data_in == SEL_SEG0) ? seg_reg_t'(bus.wr_data[4:0]) : seg0_q;
        seg1_d       = (bus.wr_en && bus.sel_mux_data_in == SEL_SEG1) ? seg_reg_t'(bus.wr_data[4:0]) : seg1_q;
        edge_d       = ((bus.rd_en && bus.sel_mux_data_out == SEL_BTN_EDGE) ? '0 : edge_q) | btn_rise;
        rd_mux       = bus.sel_mux_data_out == SEL_SEG0     ? {27'b0, seg0_q} :
                       bus.sel_mux_data_out == SEL_SEG1     ? {27'b0, seg1_q} :
                       bus.sel_mux_data_out == SEL_BTN      ? 32'(btn_stable) :
                       bus.sel_mux_data_out == SEL_BTN_EDGE ? 32'(edge_q)     : '0;
        scan_wrap    = scan_cnt_q == SW'(SCAN_DIV - 1);
        scan_cnt_d   = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_digit_d = scan_digit_q ^ scan_wrap;
    end

    // state update; display outputs are registered together from the active digit
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg0_q        <= '0;
            seg1_q        <= '0;
            edge_q        <= '0;
            scan_cnt_q    <= '0;
            scan_digit_q  <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            seg_anode_q   <= 2'b11;
            seg_cathode_q <= SEG_BLANK;
        end else begin
            seg0_q        <= seg0_d;
            seg1_q        <= seg1_d;
            edge_q        <= edge_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_digit_q  <= scan_digit_d;
            rd_valid_q    <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;
            seg_anode_q   <= scan_digit_q ? 2'b01 : 2'b10;
            seg_cathode_q <= seg_decode(scan_digit_q ? seg1_q : seg0_q);
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign seg_anode    = seg_anode_q;
    assign seg_cathode  = seg_cathode_q;
endmodule

// File: tb/tb_io_periph_v1.sv
// tb_io_periph_v1: directed checks of bus access, debounce, edge capture and scan
module tb_io_periph_v1;
    import io_periph_v1_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] btn_in;
    logic [6:0] seg_cathode;
    logic [1:0] seg_anode;
    int         checks;
    int         errors;

    io_periph_v1_if bus ();

    io_periph_v1 #(
        .NUM_BTN        (8),
        .DEBOUNCE_CYCLES(16),
        .SCAN_DIV       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .btn_in     (btn_in),
        .seg_cathode(seg_cathode),
        .seg_anode  (seg_anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] sel, input logic [31:0] data);
        bus.sel_mux_data_in = sel;
        bus.wr_data         = data;
        bus.wr_en           = 1'b1;
        tick();
        bus.wr_en           = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] sel, input logic [31:0] exp, input string tag);
        bus.sel_mux_data_out = sel;
        bus.rd_en            = 1'b1;
        tick();
        bus.rd_en            = 1'b0;
        check({tag, "_valid"}, {31'b0, bus.rd_valid}, 32'd1);
        check(tag, bus.rd_data, exp);
    endtask

    task automatic wait_anode(input logic [1:0] exp, input string tag);
        int n = 0;
        while (seg_anode !== exp && n < 40) begin
            tick();
            n++;
        end
        check(tag, {30'b0, seg_anode}, {30'b0, exp});
    endtask

    initial begin
        logic [1:0] a;
        int         n;
        checks               = 0;
        errors               = 0;
        rst                  = 1'b0;
        btn_in               = '0;
        bus.sel_mux_data_in  = SEL_NONE;
        bus.sel_mux_data_out = SEL_NONE;
        bus.wr_en            = 1'b0;
        bus.rd_en            = 1'b0;
        bus.wr_data          = '0;
        repeat (2) tick();
        check("rst_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("rst_anode", {30'b0, seg_anode}, 32'd3);
        check("rst_cathode", {25'b0, seg_cathode}, 32'h7F);
        check("rst_rd_data", bus.rd_data, 32'd0);
        rst = 1'b1;
        bus.sel_mux_data_out = SEL_SEG0;
        bus.rd_en            = 1'b1;
        check("pre_read_valid", {31'b0, bus.rd_valid}, 32'd0);
        bus.rd_en            = 1'b0;
        do_read(SEL_SEG0, 32'd0, "rst_seg0");

        do_write(SEL_SEG0, 32'h15);
        check("wr_no_valid", {31'b0, bus.rd_valid}, 32'd0);
        do_read(SEL_SEG0, 32'h15, "seg0_rd");
        tick();
        check("idle_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("idle_hold", bus.rd_data, 32'h15);

        wait_anode(2'b10, "scan_anode0");
        check("scan_cath0", {25'b0, seg_cathode}, 32'h12);
        do_write(SEL_SEG1, 32'h0A);
        wait_anode(2'b01, "scan_anode1");
        check("seg1_blank", {25'b0, seg_cathode}, 32'h7F);
        do_write(SEL_SEG1, 32'hFFFF_FF1A);
        wait_anode(2'b10, "scan_anode0b");
        wait_anode(2'b01, "scan_anode1b");
        check("seg1_A", {25'b0, seg_cathode}, 32'h08);
        do_read(SEL_SEG1, 32'h1A, "seg1_rd");

        a = seg_anode;
        n = 0;
        while (seg_anode === a && n < 20) begin
            tick();
            n++;
        end
        a = seg_anode;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("scan_period_%0d", i), {30'b0, seg_anode}, {30'b0, (i < 4) ? a : ~a});
            tick();
        end

        btn_in[0] = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        do_read(SEL_BTN, 32'd0, "db_edge18");
        do_read(SEL_BTN, 32'd1, "db_edge19");
        do_read(SEL_BTN_EDGE, 32'd1, "edge_btn0");
        btn_in[0] = 1'b0;
        repeat (20) tick();
        do_read(SEL_BTN, 32'd0, "db_release");
        do_read(SEL_BTN_EDGE, 32'd0, "fall_no_edge");

        btn_in[2] = 1'b1;
        repeat (10) tick();
        btn_in[2] = 1'b0;
        repeat (20) tick();
        do_read(SEL_BTN, 32'd0, "glitch_btn");
        do_read(SEL_BTN_EDGE, 32'd0, "glitch_edge");

        btn_in[3] = 1'b1;
        repeat (20) tick();
        do_read(SEL_BTN_EDGE, 32'h8, "edge_btn3");
        do_read(SEL_BTN_EDGE, 32'h0, "edge_cleared");
        do_read(SEL_BTN, 32'h8, "btn3_level");

        btn_in[1] = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        do_read(SEL_BTN_EDGE, 32'h0, "setwin_prior");
        do_read(SEL_BTN_EDGE, 32'h2, "setwin_next");
        do_read(SEL_BTN, 32'h0A, "btn_levels");

        bus.sel_mux_data_in  = SEL_SEG0;
        bus.wr_data          = 32'h03;
        bus.wr_en            = 1'b1;
        bus.sel_mux_data_out = SEL_SEG0;
        bus.rd_en            = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("rdwr_old", bus.rd_data, 32'h15);
        do_read(SEL_SEG0, 32'h03, "rdwr_new");

        do_write(SEL_BTN, 32'h1F);
        do_write(5'd7, 32'h1F);
        do_write(SEL_NONE, 32'h1F);
        do_write(SEL_BTN_EDGE, 32'h1F);
        do_read(SEL_SEG0, 32'h03, "ign_seg0");
        do_read(SEL_SEG1, 32'h1A, "ign_seg1");
        do_read(SEL_BTN, 32'h0A, "ign_btn");
        do_read(SEL_BTN_EDGE, 32'h0, "ign_edge");
        do_read(SEL_NONE, 32'h0, "rd_none");
        do_read(SEL_SEG1, 32'h1A, "b2b_a");
        do_read(5'd7, 32'h0, "rd_sel7");

        bus.sel_mux_data_out = SEL_SEG0;
        bus.rd_en            = 1'b1;
        rst                  = 1'b0;
        tick();
        rst       = 1'b1;
        bus.rd_en = 1'b0;
        check("midrst_valid", {31'b0, bus.rd_valid}, 32'd0);
        check("midrst_data", bus.rd_data, 32'd0);
        check("midrst_anode", {30'b0, seg_anode}, 32'd3);
        check("midrst_cathode", {25'b0, seg_cathode}, 32'h7F);
        do_read(SEL_SEG0, 32'd0, "midrst_seg0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
